input_port_buffer: RTL and testbench
====================================

// Module: input_port_buffer
// PURPOSE
//  Per-input-port flit buffer that sits upstream of the router's route-compute unit.
//  - Queues 8-bit flits from the link.
//  - Presents the header flit at the FIFO head to route compute and latches its one-hot port request.
//  - Holds that request to the switch allocator for the whole packet, dequeuing one flit per grant until the tail flit.
//  - One instance per router input (L/E/N/W/S).
// PARAMETERS
//  DEPTH       4    FIFO entries (power of two, >=2)
//  PTR_W       2    log2(DEPTH)
//  FLIT_W      8    flit width; [7:6]=type, [3:2]=dest y, [1:0]=dest x
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       synchronous reset, active-low
//  in_flit     in   FLIT_W  flit from upstream link
//  in_valid    in   1       in_flit valid
//  in_ready    out  1       buffer can accept; transfer when in_valid&in_ready
//  rc_flit     out  FLIT_W  FIFO head flit, fed to route compute (combinational)
//  rc_req      in   5       one-hot route from route compute: [0]L [1]E [2]W [3]S [4]N
//  sa_req      out  5       latched one-hot request to switch allocator
//  sa_grant    in   1       allocator grant for this port, this cycle
//  out_flit    out  FLIT_W  flit to crossbar (= FIFO head)
//  out_valid   out  1       out_flit valid toward crossbar
//  out_tail    out  1       out_flit is the last flit of its packet
//  err_drop    out  1       1-cycle pulse: a flit was discarded
// BEHAVIOUR
//  Flit types ([7:6]): HDR=2'b10, BODY=2'b00, TAIL=2'b01, HDR_TAIL=2'b11 (single-flit packet).
//  Reset (rst_n=0 at posedge): FIFO emptied, pointers and count=0, state=IDLE, route_q=0.
//    Outputs after reset: in_ready=1, sa_req=0, out_valid=0, out_tail=0, err_drop=0.
//    Reset mid-packet discards buffered flits and the held route.
//  FIFO:
//    - in_ready = (count<DEPTH). No same-cycle pass-through when full.
//    - A flit written at cycle N is at the head no earlier than N+1.
//    - Push and pop in the same cycle leave count unchanged.
//    - Pointers wrap modulo DEPTH; count is PTR_W+1 bits.
//  FSM states: IDLE, ACTIVE.
//  IDLE, FIFO empty: no action.
//  IDLE, head type HDR or HDR_TAIL:
//    - If rc_req is exactly one-hot: route_q<=rc_req, go to ACTIVE. The head is not popped.
//    - Otherwise (zero or multi-hot): pop the header, pulse err_drop, stay IDLE.
//  IDLE, head type BODY or TAIL (stray flit): pop it, pulse err_drop, stay IDLE.
//  ACTIVE:
//    - sa_req = route_q while count>0, else 5'b0.
//    - out_valid = (count>0); out_tail = head type is TAIL or HDR_TAIL.
//  Pop in ACTIVE: on sa_grant & out_valid.
//    - If the popped flit is TAIL or HDR_TAIL: go to IDLE and clear route_q.
//    - A header reaching the head next is routed in IDLE one cycle later.
//  sa_grant while out_valid=0 is ignored.
//  A HDR that reaches the head while in ACTIVE is forwarded as an ordinary flit.
//  Latency:
//    - Header written at N -> sa_req valid at N+2 at the earliest.
//    - One flit per granted cycle thereafter.
//  sa_req, out_valid, out_tail and err_drop never assert in IDLE except the err_drop pulse.
// STRUCTURE
//  Shared package (router_pkg): flit type codes HDR/BODY/TAIL/HDR_TAIL, one-hot port
//    codes PORT_L..PORT_N, FLIT_W, and the bit positions of the type/dest fields.
//  Sub-module flit_fifo (DEPTH x FLIT_W, push/pop/full/empty/count).
//  This module contains the FSM, route_q and the output decode.
// TESTING (bench wires rc_flit to the (1,2) route-compute unit, converting e1..e5 to rc_req)
//  Push 8'h8F, 8'h00, 8'h40, grant held 1:
//    - sa_req=5'b00010 (East) from cycle 2.
//    - Three flits out on consecutive cycles; out_tail=1 on 8'h40.
//    - Then sa_req=0 and FSM in IDLE.
//  Push 8'h81 (dest x1,y0), grant held 0:
//    - sa_req=5'b10000 (North) held steady.
//    - Buffer fills to 4 then in_ready=0.
//    - Grant 1: drains, in_ready=1 again after the first pop.
//  Push stray 8'h00 into an empty IDLE buffer:
//    - err_drop pulses 1 cycle, count back to 0, sa_req=0.
//  Push 8'hC6 (HDR_TAIL, dest x2,y1), grant 1:
//    - sa_req=5'b00010, one flit out with out_tail=1, back to IDLE.
//  Force rc_req=5'b00000 on header 8'h89:
//    - Header dropped with err_drop=1, FSM stays IDLE.
//  Assert rst_n=0 mid-packet after 2 of 4 flits:
//    - Next cycle: count=0, sa_req=0, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/router_pkg.sv
// ----------------------------------------------------------------------------
// router_pkg
// Shared router definitions: flit width, flit field positions, flit type
// codes, one-hot output-port codes and small flit-decode helpers.
// ----------------------------------------------------------------------------
package router_pkg;

  // Flit layout: [7:6]=type, [5:4]=unused, [3:2]=dest y, [1:0]=dest x
  localparam int unsigned FLIT_W    = 8;
  localparam int unsigned TYPE_HI   = 7;
  localparam int unsigned TYPE_LO   = 6;
  localparam int unsigned DEST_Y_HI = 3;
  localparam int unsigned DEST_Y_LO = 2;
  localparam int unsigned DEST_X_HI = 1;
  localparam int unsigned DEST_X_LO = 0;

  localparam int unsigned NUM_PORTS = 5;

  typedef enum logic [1:0] {
    FT_BODY     = 2'b00,
    FT_TAIL     = 2'b01,
    FT_HDR      = 2'b10,
    FT_HDR_TAIL = 2'b11
  } flit_type_e;

  // One-hot output-port request codes
  localparam logic [NUM_PORTS-1:0] PORT_L = 5'b00001;
  localparam logic [NUM_PORTS-1:0] PORT_E = 5'b00010;
  localparam logic [NUM_PORTS-1:0] PORT_W = 5'b00100;
  localparam logic [NUM_PORTS-1:0] PORT_S = 5'b01000;
  localparam logic [NUM_PORTS-1:0] PORT_N = 5'b10000;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } ipb_state_e;

  function automatic logic is_header(input flit_type_e t);
    return (t == FT_HDR) || (t == FT_HDR_TAIL);
  endfunction

  function automatic logic is_tail(input flit_type_e t);
    return (t == FT_TAIL) || (t == FT_HDR_TAIL);
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// ----------------------------------------------------------------------------
// flit_fifo
// Circular-buffer FIFO of DEPTH x FLIT_W. Head data is combinational from
// the read pointer; a pushed entry becomes visible at the head no earlier
// than the following cycle. Push while full and pop while empty are ignored.
//
// Ports
//   clk, rst_n  clock, synchronous active-low reset
//   push        write push_data this cycle (ignored when full)
//   push_data   entry to write
//   pop         discard head entry this cycle (ignored when empty)
//   head        current head entry
//   full        count == DEPTH
//   empty       count == 0
//   count       occupancy, PTR_W+1 bits
// ----------------------------------------------------------------------------
module flit_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2,
  parameter int unsigned FLIT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [FLIT_W-1:0] push_data,
  input  logic              pop,
  output logic [FLIT_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    cnt;
  logic              do_push;
  logic              do_pop;

  always_comb begin
    full    = (cnt == FULL_COUNT);
    empty   = (cnt == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    head    = mem[rd_ptr];
    count   = cnt;
  end

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/input_port_buffer.sv
// ----------------------------------------------------------------------------
// input_port_buffer
// Per-input-port flit buffer ahead of route compute. Queues link flits,
// presents the head flit to route compute, latches the one-hot route of a
// header and holds it toward the switch allocator for the whole packet,
// dequeuing one flit per grant until the tail flit has left.
//
// Ports
//   clk, rst_n  clock, synchronous active-low reset
//   in_flit     flit from upstream link
//   in_valid    in_flit valid
//   in_ready    buffer can accept (count < DEPTH)
//   rc_flit     FIFO head flit to route compute
//   rc_req      one-hot route from route compute [0]L [1]E [2]W [3]S [4]N
//   sa_req      held one-hot request to the switch allocator
//   sa_grant    allocator grant for this port
//   out_flit    flit to crossbar (FIFO head)
//   out_valid   out_flit valid toward crossbar
//   out_tail    out_flit is the last flit of its packet
//   err_drop    one-cycle pulse after a flit was discarded
// ----------------------------------------------------------------------------
module input_port_buffer
  import router_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [FLIT_W-1:0]    in_flit,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [FLIT_W-1:0]    rc_flit,
  input  logic [NUM_PORTS-1:0] rc_req,
  output logic [NUM_PORTS-1:0] sa_req,
  input  logic                 sa_grant,
  output logic [FLIT_W-1:0]    out_flit,
  output logic                 out_valid,
  output logic                 out_tail,
  output logic                 err_drop
);

  ipb_state_e           state;
  logic [NUM_PORTS-1:0] route_q;
  logic                 err_q;

  logic [FLIT_W-1:0]    head;
  logic                 full;
  logic                 empty;
  logic [PTR_W:0]       count;

  flit_type_e           head_type;
  logic                 head_hdr;
  logic                 head_tail;
  logic                 route_ok;
  logic                 has_flits;
  logic                 idle_accept;
  logic                 idle_drop;
  logic                 active_pop;
  logic                 fifo_push;
  logic                 fifo_pop;

  flit_fifo #(
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W),
    .FLIT_W (FLIT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (in_flit),
    .pop       (fifo_pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    head_type = flit_type_e'(head[TYPE_HI:TYPE_LO]);
    head_hdr  = is_header(head_type);
    head_tail = is_tail(head_type);
    route_ok  = $onehot(rc_req);
    has_flits = (count != '0);

    // In IDLE the head is either routed (kept in place) or discarded.
    idle_accept = (state == ST_IDLE) && !empty && head_hdr && route_ok;
    idle_drop   = (state == ST_IDLE) && !empty && !(head_hdr && route_ok);
    active_pop  = (state == ST_ACTIVE) && has_flits && sa_grant;

    in_ready  = !full;
    fifo_push = in_valid & in_ready;
    fifo_pop  = idle_drop | active_pop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      route_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= idle_drop;
      case (state)
        ST_IDLE: begin
          if (idle_accept) begin
            state   <= ST_ACTIVE;
            route_q <= rc_req;
          end
        end
        ST_ACTIVE: begin
          // Headers met here are forwarded like body flits; only a tail ends the packet.
          if (active_pop && head_tail) begin
            state   <= ST_IDLE;
            route_q <= '0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          route_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    out_valid = (state == ST_ACTIVE) && has_flits;
    sa_req    = out_valid ? route_q : '0;
    out_tail  = out_valid && head_tail;
    out_flit  = head;
    rc_flit   = head;
    err_drop  = err_q;
  end

endmodule

// File: tb/tb_input_port_buffer.sv
module tb_input_port_buffer;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_flit;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] rc_flit;
  logic [4:0] rc_req;
  logic [4:0] sa_req;
  logic       sa_grant;
  logic [7:0] out_flit;
  logic       out_valid;
  logic       out_tail;
  logic       err_drop;

  logic       ovr_en;
  logic [4:0] ovr_val;

  int tests = 0;
  int fails = 0;

  input_port_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rc_flit   (rc_flit),
    .rc_req    (rc_req),
    .sa_req    (sa_req),
    .sa_grant  (sa_grant),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .out_tail  (out_tail),
    .err_drop  (err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // XY route compute for the router at (x=1, y=2): resolve x first, then y.
  function automatic logic [4:0] xy_route(input logic [7:0] f);
    int dx;
    int dy;
    dx = int'(f[1:0]);
    dy = int'(f[3:2]);
    if (dx > 1)      return 5'b00010;
    else if (dx < 1) return 5'b00100;
    else if (dy > 2) return 5'b01000;
    else if (dy < 2) return 5'b10000;
    else             return 5'b00001;
  endfunction

  assign rc_req = ovr_en ? ovr_val : xy_route(rc_flit);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];
  bit         m_active;
  logic [4:0] m_route;
  bit         m_err;
  bit         model_ok = 0;

  function automatic bit f_is_hdr(input logic [7:0] f);
    return (f[7:6] == 2'b10) || (f[7:6] == 2'b11);
  endfunction

  function automatic bit f_is_tail(input logic [7:0] f);
    return (f[7:6] == 2'b01) || (f[7:6] == 2'b11);
  endfunction

  // Outputs are checked mid-cycle; the model then steps to the next edge
  // using the inputs that are stable until that edge.
  always @(negedge clk) begin
    int         n;
    bit         exp_ov;
    bit         do_pop;
    bit         next_err;
    logic [4:0] rc;
    n = mq.size();
    if (model_ok) begin
      exp_ov = m_active && (n > 0);
      check("in_ready", in_ready, n < 4);
      check("out_valid", out_valid, exp_ov);
      check("sa_req", sa_req, exp_ov ? m_route : 5'b0);
      check("out_tail", out_tail, exp_ov && f_is_tail(mq[0]));
      check("err_drop", err_drop, m_err);
      if (n > 0) check("rc_flit", rc_flit, mq[0]);
      if (exp_ov) check("out_flit", out_flit, mq[0]);
    end
    if (!rst_n) begin
      mq.delete();
      m_active = 0;
      m_route  = '0;
      m_err    = 0;
      model_ok = 1;
    end else if (model_ok) begin
      do_pop   = 0;
      next_err = 0;
      if (n > 0) begin
        rc = ovr_en ? ovr_val : xy_route(mq[0]);
        if (!m_active) begin
          if (f_is_hdr(mq[0]) && $countones(rc) == 1) begin
            m_active = 1;
            m_route  = rc;
          end else begin
            do_pop   = 1;
            next_err = 1;
          end
        end else if (sa_grant) begin
          do_pop = 1;
          if (f_is_tail(mq[0])) begin
            m_active = 0;
            m_route  = '0;
          end
        end
      end
      if (do_pop) void'(mq.pop_front());
      if (in_valid && n < 4) mq.push_back(in_flit);
      m_err = next_err;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_flit(input logic [7:0] f);
    in_valid = 1'b1;
    in_flit  = f;
    tick();
  endtask

  initial begin
    logic [7:0] f;
    int         r;
    rst_n = 1'b0; in_valid = 1'b0; in_flit = '0; sa_grant = 1'b0;
    ovr_en = 1'b0; ovr_val = '0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_sa_req", sa_req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_tail", out_tail, 0);
    check("rst_err_drop", err_drop, 0);

    // East packet, grant held
    push_flit(8'h8F);
    push_flit(8'h00);
    check("s1_sa_req", sa_req, 5'b00010);
    check("s1_out0", out_flit, 8'h8F);
    check("s1_tail0", out_tail, 0);
    sa_grant = 1'b1;
    push_flit(8'h40);
    check("s1_out1", out_flit, 8'h00);
    in_valid = 1'b0;
    tick();
    check("s1_out2", out_flit, 8'h40);
    check("s1_tail2", out_tail, 1);
    tick();
    check("s1_idle_req", sa_req, 0);
    check("s1_idle_ov", out_valid, 0);
    sa_grant = 1'b0;

    // North packet fills the buffer while ungranted
    push_flit(8'h81);
    push_flit(8'h00);
    check("s2_sa_req", sa_req, 5'b10000);
    push_flit(8'h00);
    push_flit(8'h40);
    check("s2_full", in_ready, 0);
    in_valid = 1'b0;
    tick(); tick();
    check("s2_hold_req", sa_req, 5'b10000);
    check("s2_head", out_flit, 8'h81);
    sa_grant = 1'b1;
    tick();
    check("s2_ready_again", in_ready, 1);
    tick(); tick(); tick();
    check("s2_drained", sa_req, 0);
    check("s2_drained_ov", out_valid, 0);
    sa_grant = 1'b0;

    // Stray body flit into an idle buffer
    push_flit(8'h00);
    in_valid = 1'b0;
    tick();
    check("s3_err", err_drop, 1);
    check("s3_sa_req", sa_req, 0);
    check("s3_empty", in_ready, 1);
    tick();
    check("s3_err_end", err_drop, 0);

    // Single-flit packet
    push_flit(8'hC6);
    in_valid = 1'b0;
    sa_grant = 1'b1;
    tick();
    check("s4_sa_req", sa_req, 5'b00010);
    check("s4_tail", out_tail, 1);
    check("s4_out", out_flit, 8'hC6);
    tick();
    check("s4_idle", sa_req, 0);
    check("s4_idle_ov", out_valid, 0);
    sa_grant = 1'b0;

    // Header with no route is dropped
    ovr_en = 1'b1; ovr_val = 5'b00000;
    push_flit(8'h89);
    in_valid = 1'b0;
    tick();
    check("s5_err", err_drop, 1);
    check("s5_sa_req", sa_req, 0);
    check("s5_ov", out_valid, 0);
    ovr_en = 1'b0;
    tick();

    // Reset mid-packet
    push_flit(8'h82);
    push_flit(8'h00);
    push_flit(8'h00);
    push_flit(8'h40);
    in_valid = 1'b0;
    sa_grant = 1'b1;
    tick(); tick();
    sa_grant = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("s6_ready", in_ready, 1);
    check("s6_sa_req", sa_req, 0);
    check("s6_ov", out_valid, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      f = 8'($urandom);
      if (r < 30)      f[7:6] = 2'b10;
      else if (r < 70) f[7:6] = 2'b00;
      else if (r < 90) f[7:6] = 2'b01;
      else             f[7:6] = 2'b11;
      in_flit  = f;
      in_valid = ($urandom_range(0, 99) < 60);
      sa_grant = ($urandom_range(0, 99) < 50);
      ovr_en   = ($urandom_range(0, 99) < 15);
      ovr_val  = 5'($urandom);
      rst_n    = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1; in_valid = 1'b0; sa_grant = 1'b0; ovr_en = 1'b0;
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
